// File: rtl/alu_seq_pkg.sv
// Shared types, ALU control encodings and instruction field positions for the
// ALU issue/write-back sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100,
    OP_LI  = 3'b101
  } op_t;

  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;
  localparam logic [1:0] CTRL_AND = 2'b10;
  localparam logic [1:0] CTRL_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 7;
  localparam int RT_MSB  = 6;
  localparam int RT_LSB  = 4;
  localparam int IMM_MSB = 9;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  // ALU control for an opcode; illegal opcodes drive ADD.
  function automatic logic [1:0] ctrl_of(input logic [2:0] op);
    case (op)
      OP_ADD, OP_LI:  ctrl_of = CTRL_ADD;
      OP_SUB, OP_SLT: ctrl_of = CTRL_SUB;
      OP_AND:         ctrl_of = CTRL_AND;
      OP_OR:          ctrl_of = CTRL_OR;
      default:        ctrl_of = CTRL_ADD;
    endcase
  endfunction

  // Opcodes 110 and 111 are unassigned.
  function automatic logic op_legal(input logic [2:0] op);
    op_legal = (op <= 3'(OP_LI));
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU drive/return and debug read signals of the
// sequencer, bundled so the harness and the sequencer share one port list.
interface alu_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [1:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_lt;
  logic              done;
  logic              err;
  logic [AW-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  // Sequencer side.
  modport slave (
    input  instr_valid, instr, alu_result, alu_lt, dbg_addr,
    output instr_ready, alu_ctrl, alu_a, alu_b, done, err, dbg_data
  );

  // Instruction source / ALU / debug side.
  modport master (
    output instr_valid, instr, alu_result, alu_lt, dbg_addr,
    input  instr_ready, alu_ctrl, alu_a, alu_b, done, err, dbg_data
  );
endinterface

// File: rtl/seq_regfile.sv
// Register file for the sequencer: two combinational operand reads, one
// combinational debug read, one synchronous write; register 0 reads zero.
module seq_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Clear on reset; writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs_data  = (rs_addr  == '0) ? '0 : regs[rs_addr];
  assign rt_data  = (rt_addr  == '0) ? '0 : regs[rt_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle issue/write-back controller for the external 2-bit-ctrl ALU:
// IDLE accepts an instruction, DECODE loads operands, EXEC presents them to
// the ALU and captures its result, WB writes back and pulses done.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  state_t            state;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [1:0]        ctrl_q;
  logic [DATA_W-1:0] res;
  logic              lt;
  logic              done_q;
  logic              err_q;

  logic [2:0]        op;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              we;
  logic [DATA_W-1:0] wr_data;

  assign op      = instr_q[OP_MSB:OP_LSB];
  assign rd_addr = AW'(instr_q[RD_MSB:RD_LSB]);
  assign rs_addr = AW'(instr_q[RS_MSB:RS_LSB]);
  assign rt_addr = AW'(instr_q[RT_MSB:RT_LSB]);

  // Write-back happens during WB so the next DECODE already sees the value.
  assign we      = (state == S_WB) && op_legal(op);
  assign wr_data = (op == 3'(OP_SLT)) ? {{(DATA_W-1){1'b0}}, lt} : res;

  seq_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .dbg_addr (bus.dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (bus.dbg_data),
    .we       (we),
    .wr_addr  (rd_addr),
    .wr_data  (wr_data)
  );

  // Sequencer FSM with registered ALU drive, result capture and done/err pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      instr_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      ctrl_q  <= CTRL_ADD;
      res     <= '0;
      lt      <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op == 3'(OP_LI)) begin
            op_a <= '0;
            op_b <= {{(DATA_W-IMM_W){1'b0}}, instr_q[IMM_MSB:IMM_LSB]};
          end else begin
            op_a <= rs_data;
            op_b <= rt_data;
          end
          ctrl_q <= ctrl_of(op);
          state  <= S_EXEC;
        end
        S_EXEC: begin
          res    <= bus.alu_result;
          lt     <= bus.alu_lt;
          done_q <= 1'b1;
          err_q  <= ~op_legal(op);
          state  <= S_WB;
        end
        S_WB: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.alu_ctrl    = ctrl_q;
  assign bus.alu_a       = op_a;
  assign bus.alu_b       = op_b;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions with hand-computed
// results, a behavioural ALU, and a monitor that checks every done pulse.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;
  int   pending = 0;

  alu_sequencer_if #(.DATA_W(16), .AW(3)) bus ();

  alu_sequencer #(.DATA_W(16), .NREGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural combinational ALU; LT is bit 15 of a-b.
  logic [15:0] diff;
  always_comb begin
    diff           = bus.alu_a - bus.alu_b;
    bus.alu_result = 16'h0000;
    case (bus.alu_ctrl)
      2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_result = diff;
      2'b10:   bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = bus.alu_a | bus.alu_b;
    endcase
    bus.alu_lt = diff[15];
  end

  // Debug address is shared between the monitor (after each done) and stimulus.
  logic       mon_owns = 1'b0;
  logic [2:0] dbg_mon = 3'd0;
  logic [2:0] dbg_stim = 3'd0;
  assign bus.dbg_addr = mon_owns ? dbg_mon : dbg_stim;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
    logic [1:0]  ctrl;
    logic        er;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] rtype(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  function automatic logic [15:0] li(input logic [2:0] rd, input logic [9:0] imm);
    return {3'b101, rd, imm};
  endfunction

  task automatic issue(input logic [15:0] w, input logic [15:0] val, input logic [1:0] ctrl,
                       input logic er, input bit keep, input bit expect_it, output int acc);
    int n;
    exp_t e;
    @(negedge clk);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) check("accept_timeout", 32'd0, 32'd1);
    acc = cyc;
    @(posedge clk);
    if (expect_it) begin
      e.rd = w[12:10]; e.val = val; e.ctrl = ctrl; e.er = er; e.acc = acc;
      exp_q.push_back(e);
      pending++;
    end
    #1;
    if (!keep) bus.instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pending != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (pending != 0) check("drain_timeout", 32'(pending), 32'd0);
  endtask

  task automatic dbg_check(input string name, input logic [2:0] a, input logic [15:0] req);
    @(negedge clk);
    dbg_stim = a;
    #1;
    check(name, 32'(bus.dbg_data), 32'(req));
  endtask

  // Monitor: every done pulse pops one expectation and checks it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_latency", 32'(cyc - e.acc), 32'd3);
          check("err_flag", 32'(bus.err), 32'(e.er));
          check("alu_ctrl", 32'(bus.alu_ctrl), 32'(e.ctrl));
          dbg_mon  = e.rd;
          mon_owns = 1'b1;
          @(posedge clk);
          #1;
          check("writeback_value", 32'(bus.dbg_data), 32'(e.val));
          mon_owns = 1'b0;
          pending--;
        end
      end else if (bus.err) begin
        check("err_without_done", 32'(bus.err), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b), 32'd0);
    for (int i = 0; i < 8; i++) dbg_check("rst_regfile", 3'(i), 16'h0000);

    issue(li(3'd1, 10'h005), 16'h0005, 2'b00, 1'b0, 1'b0, 1'b1, a0); drain();
    issue(li(3'd2, 10'h003), 16'h0003, 2'b00, 1'b0, 1'b0, 1'b1, a0); drain();
    issue(rtype(3'b000, 3'd3, 3'd1, 3'd2), 16'h0008, 2'b00, 1'b0, 1'b0, 1'b1, a0); drain();
    issue(rtype(3'b001, 3'd4, 3'd2, 3'd1), 16'hFFFE, 2'b01, 1'b0, 1'b0, 1'b1, a0); drain();
    issue(rtype(3'b100, 3'd5, 3'd2, 3'd1), 16'h0001, 2'b01, 1'b0, 1'b0, 1'b1, a0); drain();
    issue(rtype(3'b100, 3'd6, 3'd1, 3'd2), 16'h0000, 2'b01, 1'b0, 1'b0, 1'b1, a0); drain();
    issue(li(3'd1, 10'h3F0), 16'h03F0, 2'b00, 1'b0, 1'b0, 1'b1, a0); drain();
    issue(li(3'd2, 10'h0FF), 16'h00FF, 2'b00, 1'b0, 1'b0, 1'b1, a0); drain();
    issue(rtype(3'b010, 3'd3, 3'd1, 3'd2), 16'h00F0, 2'b10, 1'b0, 1'b0, 1'b1, a0); drain();
    issue(rtype(3'b011, 3'd4, 3'd1, 3'd2), 16'h03FF, 2'b11, 1'b0, 1'b0, 1'b1, a0); drain();
    // Illegal opcode: r3 must keep 0x00F0.
    issue(rtype(3'b111, 3'd3, 3'd1, 3'd2), 16'h00F0, 2'b00, 1'b1, 1'b0, 1'b1, a0); drain();
    issue(rtype(3'b000, 3'd0, 3'd1, 3'd2), 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1, a0); drain();

    // instr_valid held high across three instructions.
    issue(rtype(3'b000, 3'd5, 3'd1, 3'd2), 16'h04EF, 2'b00, 1'b0, 1'b1, 1'b1, a0);
    issue(rtype(3'b001, 3'd6, 3'd1, 3'd2), 16'h02F1, 2'b01, 1'b0, 1'b1, 1'b1, a1);
    issue(li(3'd7, 10'h2AA), 16'h02AA, 2'b00, 1'b0, 1'b0, 1'b1, a2);
    check("accept_spacing_1", 32'(a1 - a0), 32'd4);
    check("accept_spacing_2", 32'(a2 - a1), 32'd4);
    drain();
    dbg_check("r1_before_abort", 3'd1, 16'h03F0);

    // Reset during EXEC of ADD r7: no write-back, no done.
    issue(rtype(3'b000, 3'd7, 3'd1, 3'd2), 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, a0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    repeat (4) @(negedge clk);
    dbg_check("abort_r7", 3'd7, 16'h0000);
    dbg_check("abort_r1_cleared", 3'd1, 16'h0000);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle issue/write-back controller that drives the 16-bit, 2-bit-ctrl ALU.
- Accepts one 16-bit instruction per valid/ready handshake, reads operands from an internal 8x16 register file, and drives ALU ctrl and operands.
- Captures the ALU result and LT flag, writes the result back, then pulses done.
- Sits between the instruction source (test harness / future fetch unit) and the ALU.

Parameters:
- DATA_W, 16, datapath width; must match the ALU.
- NREGS, 8, register-file depth; register 0 always reads zero.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction available
- instr  input  16  instruction word: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [9:0] imm10 (LI only)
- instr_ready  output  1  high only in IDLE
- alu_ctrl  output  2  to ALU: 00 add, 01 sub, 10 and, 11 or
- alu_a  output  16  to ALU operand A
- alu_b  output  16  to ALU operand B
- alu_result  input  16  from ALU, combinational
- alu_lt  input  1  from ALU: sub result negative
- done  output  1  one-cycle pulse at write-back
- err  output  1  one-cycle pulse with done for an illegal opcode
- dbg_addr  input  3  debug register-file read address
- dbg_data  output  16  combinational read of reg[dbg_addr]; 0 when dbg_addr = 0

Behaviour:
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR: rd <= rs op rt.
  - 100 SLT: alu_ctrl = 01; rd <= {15'b0, alu_lt}.
  - 101 LI: alu_ctrl = 00, a = 0, b = zero-extended imm10; rd <= result.
  - 110 and 111 are illegal.
- FSM states IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch instr and go to DECODE.
  - instr is ignored when not ready; no queueing.
- DECODE:
  - Read rs and rt from the register file into operand registers op_a and op_b.
  - Register 0 reads 0.
  - Compute alu_ctrl from op; ctrl for illegal ops is don't-care but drive 00.
- EXEC:
  - alu_a, alu_b and alu_ctrl are registered outputs, stable for the whole cycle.
  - Capture alu_result and alu_lt into res/lt registers at the end of EXEC.
- WB:
  - Write reg[rd] unless rd = 0 or op is illegal.
  - Assert done = 1; assert err = 1 if op is illegal.
  - Next state is IDLE.
- Latency:
  - Handshake cycle N; done at cycle N+3.
  - Next instruction accepted no earlier than cycle N+4.
- Outputs held between ops: alu_a, alu_b and alu_ctrl keep their last values outside EXEC, which is harmless because the ALU is combinational.
- Arithmetic:
  - Modulo 2^16; carry and overflow ignored.
  - SLT is signed-by-sign-bit, i.e. it reports bit 15 of a-b, matching the ALU's LT definition (not true signed compare on overflow).
- Reset:
  - All registers and regs[1..7] <= 0; state <= IDLE.
  - Outputs after reset: instr_ready = 1, done = 0, err = 0, alu_ctrl = 00, alu_a = 0, alu_b = 0.
  - Reset in any state aborts the op with no write-back and no done.
- Write to rd = 0: still pulses done; no state change.
- Back-to-back read-after-write: the next instruction's DECODE sees the WB value, because WB completes before IDLE.

Decomposition:
- Package alu_seq_pkg:
  - op_t enum (OP_ADD..OP_LI).
  - alu_ctrl constants (CTRL_ADD = 2'b00, CTRL_SUB = 2'b01, CTRL_AND = 2'b10, CTRL_OR = 2'b11).
  - state_t enum.
  - Field-slice localparams for instr.
- One sub-module, seq_regfile: 8x16, two combinational read ports plus the debug port, one synchronous write port, register 0 hardwired to zero.

Test Plan:
- Reset, then check outputs: instr_ready = 1, done = 0, dbg_data = 0 for every address.
- LI r1 = 0x005; LI r2 = 0x003; ADD r3, r1, r2 -> done 3 cycles after each accept; dbg r3 = 0x0008; alu_ctrl = 00 in EXEC.
- SUB r4, r2, r1 -> r4 = 0xFFFE; SLT r5, r2, r1 -> r5 = 0x0001; SLT r6, r1, r2 -> r6 = 0x0000.
- LI r1 = 0x3F0, LI r2 = 0x0FF; AND r3 -> 0x00F0; OR r4 -> 0x03FF; alu_ctrl = 10 then 11.
- Opcode 111 with rd = 3 -> done and err pulse together, r3 unchanged; ADD r0, r1, r2 -> done, dbg r0 = 0.
- Hold instr_valid high continuously with 3 instrs -> exactly one accept per 4 cycles. Assert reset during EXEC of ADD r7 -> r7 = 0, no done, instr_ready = 1 next cycle.
